// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential signed shift-and-add multiplier with busy/done status
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // Counter is one bit wider than strictly needed so the final increment never wraps.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CW-1:0]      count;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned number.
    assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, CALC always runs the full WIDTH cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture magnitudes on accept, shift-and-add in CALC, apply sign in FIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_b   <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_b <= abs_b;
                        mcand <= {{WIDTH{1'b0}}, abs_a};
                        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (mag_b[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mag_b <= mag_b >> 1;
                    count <= count + 1'b1;
                end
                FIN: begin
                    // A zero magnitude product stays +0 because negating zero yields zero.
                    product <= neg ? (~acc + 1'b1) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed scoreboard bench for seq_multiplier
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    logic [2*WIDTH-1:0] exp_q[$];

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: plain signed integer multiplication.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[2*WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pulse start for one edge; optionally record the expected product.
    task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit push);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back(ref_mul(av, bv));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge right after the accept edge. Bit k of mask drives a
    // stray start (a=2,b=2) into edge k. Returns at the negedge where done is high.
    task automatic wait_done(input string tag, input logic [31:0] mask);
        int  cnt;
        bit  seen;
        bit  busy_ok;
        logic [2*WIDTH-1:0] expv;
        cnt     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (cnt < 20 && !seen) begin
            if (mask[cnt+1]) begin
                start = 1'b1;
                a     = 8'd2;
                b     = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
            if (done) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cnt, 32'd9);
        check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            check({tag, "_product"}, {16'd0, product}, {16'd0, expv});
        end else begin
            check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        do_start(av, bv, 1'b1);
        check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        wait_done(tag, 32'd0);
        after_done(tag);
    endtask

    initial begin
        int dcount;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        @(negedge clk);
        check("reset_product", {16'd0, product}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic operation and sign coverage
        run_op("p7x6", 8'd7, 8'd6);
        check("p7x6_const", {16'd0, product}, 32'h002A);
        run_op("m3x5", 8'hFD, 8'd5);
        check("m3x5_const", {16'd0, product}, 32'hFFF1);
        run_op("m128xm128", 8'h80, 8'h80);
        check("m128xm128_const", {16'd0, product}, 32'h4000);
        run_op("p127xm128", 8'd127, 8'h80);
        check("p127xm128_const", {16'd0, product}, 32'hC080);
        run_op("zeroxm1", 8'd0, 8'hFF);
        check("zeroxm1_const", {16'd0, product}, 32'h0000);

        // Start pulses at edges 3 and 9 (CALC and FIN) must be ignored
        do_start(8'd10, 8'd10, 1'b1);
        wait_done("ignore", (32'd1 << 3) | (32'd1 << 9));
        dcount = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ignore_no_second_done", dcount, 32'd0);
        check("ignore_product_held", {16'd0, product}, 32'd100);
        check("ignore_busy_idle", {31'd0, busy}, 32'd0);

        // Back-to-back: start in the done cycle
        do_start(8'd5, 8'd5, 1'b1);
        wait_done("b2b_first", 32'd0);
        a     = 8'hFC;
        b     = 8'd3;
        start = 1'b1;
        exp_q.push_back(ref_mul(8'hFC, 8'd3));
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_cleared", {31'd0, done}, 32'd0);
        check("b2b_busy_again", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", 32'd0);
        check("b2b_second_const", {16'd0, product}, 32'hFFF4);
        after_done("b2b_second");

        // Asynchronous reset mid-CALC
        do_start(8'd9, 8'd9, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_product", {16'd0, product}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midrst_no_activity", dcount, 32'd0);
        run_op("post_rst", 8'd2, 8'd3);
        check("post_rst_const", {16'd0, product}, 32'd6);

        // Operands change after acceptance
        do_start(8'd4, 8'd4, 1'b1);
        a = 8'hFF;
        b = 8'hFF;
        wait_done("opchg", 32'd0);
        check("opchg_const", {16'd0, product}, 32'd16);
        after_done("opchg");

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bench-wide safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
